// File: rtl/uart_pkg.sv
// Shared UART defaults used as parameter defaults across the receive path.
package uart_pkg;

  localparam int unsigned UART_DATA_WIDTH    = 8;
  localparam int unsigned UART_RX_FIFO_DEPTH = 16;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Bus/deserializer-side signal bundle of the UART receive FIFO.
interface uart_rx_fifo_if
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH,
  parameter int unsigned DEPTH      = UART_RX_FIFO_DEPTH
);

  logic [DATA_WIDTH-1:0]    Rx_Data;
  logic                     Rx_Valid;
  logic                     Rd_En;
  logic [DATA_WIDTH-1:0]    Rd_Data;
  logic                     Empty;
  logic                     Full;
  logic [$clog2(DEPTH):0]   Count;
  logic                     Overrun;
  logic                     Ovr_Clr;
  logic [$clog2(DEPTH):0]   Thresh;
  logic                     Irq;

  modport master (
    output Rx_Data, Rx_Valid, Rd_En, Ovr_Clr, Thresh,
    input  Rd_Data, Empty, Full, Count, Overrun, Irq
  );

  modport slave (
    input  Rx_Data, Rx_Valid, Rd_En, Ovr_Clr, Thresh,
    output Rd_Data, Empty, Full, Count, Overrun, Irq
  );

endinterface

// File: rtl/uart_rx_fifo_mem.sv
// DEPTH x DATA_WIDTH register array: one synchronous write port, one asynchronous read port.
module uart_rx_fifo_mem
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH,
  parameter int unsigned DEPTH      = UART_RX_FIFO_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0]    wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0]    rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: pointers, occupancy, sticky overrun and optional level interrupt.
// Define UART_RX_FIFO_IRQ_EN to build the threshold/overrun interrupt; otherwise Irq is 0.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH,
  parameter int unsigned DEPTH      = UART_RX_FIFO_DEPTH
) (
  input logic           CLK,
  input logic           RST,
  uart_rx_fifo_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overrun_q, overrun_d;
  logic                  empty, full, wr_fire, rd_fire, drop;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  always_comb begin
    rd_fire   = bus.Rd_En && !empty;
    // A full FIFO still accepts a byte when the same cycle pops the head.
    wr_fire   = bus.Rx_Valid && (!full || bus.Rd_En);
    drop      = bus.Rx_Valid && full && !bus.Rd_En;
    wr_ptr_d  = wr_fire ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = rd_fire ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d   = count_q + CW'(wr_fire) - CW'(rd_fire);
    overrun_d = drop || (overrun_q && !bus.Ovr_Clr);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  uart_rx_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk_i   (CLK),
    .we_i    (wr_fire),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.Rx_Data),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  assign bus.Rd_Data = empty ? '0 : mem_rdata;
  assign bus.Empty   = empty;
  assign bus.Full    = full;
  assign bus.Count   = count_q;
  assign bus.Overrun = overrun_q;

`ifdef UART_RX_FIFO_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = ((bus.Thresh != '0) && (count_d >= bus.Thresh)) || overrun_d;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign bus.Irq = irq_q;
`else
  logic unused_thresh;
  assign unused_thresh = ^bus.Thresh;
  assign bus.Irq       = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based reference model plus directed literal checks.
module tb_uart_rx_fifo;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;
`ifdef UART_RX_FIFO_IRQ_EN
  localparam bit IrqOn = 1'b1;
`else
  localparam bit IrqOn = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;
  bit   done    = 1'b0;

  uart_rx_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: an ordered queue of stored bytes plus flag state.
  logic [DW-1:0] mq [$];
  bit            m_ovr = 1'b0;
  bit            m_irq = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      mq.delete();
      m_ovr = 1'b0;
      m_irq = 1'b0;
    end else begin
      bit was_full, was_empty, set_ovr;
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      set_ovr   = bus.Rx_Valid && was_full && !bus.Rd_En;
      if (bus.Rd_En && !was_empty) void'(mq.pop_front());
      if (bus.Rx_Valid && (!was_full || bus.Rd_En)) mq.push_back(bus.Rx_Data);
      m_ovr = set_ovr || (m_ovr && !bus.Ovr_Clr);
      m_irq = IrqOn && (((bus.Thresh != 0) && (mq.size() >= int'(bus.Thresh))) || m_ovr);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Compare every cycle, away from the active edge.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (!done) begin
        chk("m_rd_data", 32'(bus.Rd_Data), (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
        chk("m_count",   32'(bus.Count),   32'(mq.size()));
        chk("m_empty",   32'(bus.Empty),   32'(mq.size() == 0));
        chk("m_full",    32'(bus.Full),    32'(mq.size() == DEPTH));
        chk("m_overrun", 32'(bus.Overrun), 32'(m_ovr));
        chk("m_irq",     32'(bus.Irq),     32'(m_irq));
      end
    end
  end

  task automatic step(input logic v, input logic [DW-1:0] d, input logic r, input logic c);
    bus.Rx_Valid = v;
    bus.Rx_Data  = d;
    bus.Rd_En    = r;
    bus.Ovr_Clr  = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst          = 1'b0;
    bus.Rx_Valid = 1'b0;
    bus.Rx_Data  = '0;
    bus.Rd_En    = 1'b0;
    bus.Ovr_Clr  = 1'b0;
    bus.Thresh   = '0;
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 0);
    rst = 1'b1;
    chk("rst_count", 32'(bus.Count), 0);
    chk("rst_empty", 32'(bus.Empty), 1);
    chk("rst_rd",    32'(bus.Rd_Data), 0);

    step(1, 8'hA5, 0, 0);
    chk("wr1_rd",    32'(bus.Rd_Data), 32'hA5);
    chk("wr1_count", 32'(bus.Count), 1);
    chk("wr1_empty", 32'(bus.Empty), 0);
    step(0, 8'h00, 1, 0);
    chk("pop1_empty", 32'(bus.Empty), 1);
    chk("pop1_rd",    32'(bus.Rd_Data), 0);

    for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0);
    chk("fill_full",  32'(bus.Full), 1);
    chk("fill_count", 32'(bus.Count), 16);
    step(1, 8'h55, 0, 0);
    chk("drop_ovr",   32'(bus.Overrun), 1);
    chk("drop_head",  32'(bus.Rd_Data), 32'h00);
    chk("drop_count", 32'(bus.Count), 16);
    step(0, 8'h00, 0, 1);
    chk("clr_ovr",    32'(bus.Overrun), 0);

    step(1, 8'h77, 1, 0);
    chk("fullrw_count", 32'(bus.Count), 16);
    chk("fullrw_head",  32'(bus.Rd_Data), 32'h01);
    chk("fullrw_ovr",   32'(bus.Overrun), 0);
    for (int i = 0; i < 15; i++) step(0, 8'h00, 1, 0);
    chk("drain_last", 32'(bus.Rd_Data), 32'h77);
    step(0, 8'h00, 1, 0);
    chk("drain_empty", 32'(bus.Empty), 1);

    step(1, 8'h77, 1, 0);
    chk("emptyrw_count", 32'(bus.Count), 1);
    chk("emptyrw_rd",    32'(bus.Rd_Data), 32'h77);
    step(0, 8'h00, 1, 0);

    // Pointer wrap: hold 10 entries while 40 simultaneous read/write cycles go by.
    for (int i = 0; i < 10; i++) step(1, 8'(8'h80 + i), 0, 0);
    for (int i = 0; i < 40; i++) step(1, 8'(8'hC0 + i), 1, 0);
    chk("wrap_count", 32'(bus.Count), 10);
    chk("wrap_head",  32'(bus.Rd_Data), 32'hDE);
    for (int i = 0; i < 6; i++) step(1, 8'(8'hF0 + i), 0, 0);
    step(1, 8'h99, 0, 1);
    chk("setwins_ovr", 32'(bus.Overrun), 1);
    step(0, 8'h00, 0, 1);
    chk("clr2_ovr", 32'(bus.Overrun), 0);

    for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0);
    bus.Thresh = 5'd4;
    for (int i = 0; i < 3; i++) step(1, 8'(8'h10 + i), 0, 0);
    chk("th_below_irq", 32'(bus.Irq), 0);
    step(1, 8'h13, 0, 0);
    chk("th_hit_irq",   32'(bus.Irq), 32'(IrqOn));
    chk("th_hit_count", 32'(bus.Count), 4);
    step(0, 8'h00, 1, 0);
    chk("th_pop_irq",   32'(bus.Irq), 0);
    bus.Thresh = 5'd0;
    for (int i = 0; i < 13; i++) step(1, 8'(8'h20 + i), 0, 0);
    chk("th0_full_irq", 32'(bus.Irq), 0);
    step(1, 8'hEE, 0, 0);
    chk("th0_ovr_irq",  32'(bus.Irq), 32'(IrqOn));

    for (int i = 0; i < 11; i++) step(0, 8'h00, 1, 0);
    chk("pre_rst_count", 32'(bus.Count), 5);
    rst = 1'b0;
    step(0, 8'h00, 0, 0);
    rst = 1'b1;
    chk("mid_rst_count", 32'(bus.Count), 0);
    chk("mid_rst_empty", 32'(bus.Empty), 1);
    chk("mid_rst_ovr",   32'(bus.Overrun), 0);
    chk("mid_rst_irq",   32'(bus.Irq), 0);
    step(1, 8'h3C, 0, 0);
    chk("post_rst_rd",    32'(bus.Rd_Data), 32'h3C);
    chk("post_rst_count", 32'(bus.Count), 1);

    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 0);
    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
